// File: rtl/tlul_reg_adapter_dev.sv
// TL-UL device adapter: turns single-beat Get/Put requests into a simple register-port
// request/grant/rvalid handshake and returns one D beat per request.
//
// state | meaning
// IDLE  | ready for a new A beat
// REQ   | reg_req_o high, waiting for reg_gnt_i
// WAIT  | granted, waiting for reg_rvalid_i
// RESP  | d_valid_o high until the host takes the D beat
module tlul_reg_adapter_dev #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int AIW = 8,
  parameter int SZW = 2,
  localparam int DBW = DW / 8
) (
  input  logic           clk_i,
  input  logic           rst_i,

  input  logic           a_valid_i,
  input  logic [2:0]     a_opcode_i,
  input  logic [2:0]     a_param_i,
  input  logic [SZW-1:0] a_size_i,
  input  logic [AIW-1:0] a_source_i,
  input  logic [AW-1:0]  a_address_i,
  input  logic [DBW-1:0] a_mask_i,
  input  logic [DW-1:0]  a_data_i,
  output logic           a_ready_o,

  output logic           d_valid_o,
  output logic [2:0]     d_opcode_o,
  output logic [SZW-1:0] d_size_o,
  output logic [AIW-1:0] d_source_o,
  output logic [DW-1:0]  d_data_o,
  output logic           d_error_o,
  input  logic           d_ready_i,

  output logic           reg_req_o,
  output logic           reg_we_o,
  output logic [AW-1:0]  reg_addr_o,
  output logic [DW-1:0]  reg_wdata_o,
  output logic [DBW-1:0] reg_be_o,
  input  logic           reg_gnt_i,
  input  logic           reg_rvalid_i,
  input  logic [DW-1:0]  reg_rdata_i,
  input  logic           reg_err_i
);

  localparam int OFFW = $clog2(DBW);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] D_ACK          = 3'd0;
  localparam logic [2:0] D_ACK_DATA     = 3'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [SZW-1:0] size_q;
  logic [AIW-1:0] source_q;
  logic [AW-1:0]  addr_q;
  logic [DBW-1:0] mask_q;
  logic [DW-1:0]  wdata_q;

  logic [DBW-1:0] size_lanes;
  logic [DBW-1:0] lanes;
  logic           aligned;
  logic           op_ok;
  logic           mask_ok;
  logic           legal;
  logic           a_get;
  logic           is_get;
  logic [DW-1:0]  resp_data;

  // Byte lanes a request of this size/address may touch; oversize requests get none.
  always_comb begin
    size_lanes = '0;
    aligned    = 1'b0;
    case (a_size_i)
      SZW'(0): begin
        size_lanes = DBW'(4'h1);
        aligned    = 1'b1;
      end
      SZW'(1): begin
        size_lanes = DBW'(4'h3);
        aligned    = ~a_address_i[0];
      end
      SZW'(2): begin
        size_lanes = DBW'(4'hF);
        aligned    = (a_address_i[1:0] == 2'b00);
      end
      default: ;
    endcase
    lanes = size_lanes << a_address_i[OFFW-1:0];
  end

  assign a_get   = (a_opcode_i == OP_GET);
  assign op_ok   = a_get || (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PARTIAL);
  assign mask_ok = (a_mask_i != '0) && ((a_mask_i & ~lanes) == '0) &&
                   ((a_opcode_i != OP_PUT_FULL) || (a_mask_i == lanes));
  assign legal   = op_ok && (a_param_i == 3'd0) && aligned && mask_ok;

  assign is_get    = (op_q == OP_GET);
  assign resp_data = is_get ? (reg_err_i ? '1 : reg_rdata_i) : '0;

  assign a_ready_o   = (state == IDLE) && !rst_i;
  assign d_size_o    = size_q;
  assign d_source_o  = source_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_be_o    = mask_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      op_q       <= '0;
      size_q     <= '0;
      source_q   <= '0;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      d_valid_o  <= 1'b0;
      d_opcode_o <= D_ACK;
      d_data_o   <= '0;
      d_error_o  <= 1'b0;
      reg_req_o  <= 1'b0;
      reg_we_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid_i) begin
            op_q       <= a_opcode_i;
            size_q     <= a_size_i;
            source_q   <= a_source_i;
            addr_q     <= {a_address_i[AW-1:2], 2'b00};
            mask_q     <= a_mask_i;
            wdata_q    <= a_data_i;
            d_opcode_o <= a_get ? D_ACK_DATA : D_ACK;
            if (legal) begin
              state     <= REQ;
              reg_req_o <= 1'b1;
              reg_we_o  <= !a_get;
            end else begin
              // Rejected locally: the register port never sees this request.
              state     <= RESP;
              d_valid_o <= 1'b1;
              d_error_o <= 1'b1;
              d_data_o  <= a_get ? '1 : '0;
            end
          end
        end
        REQ: begin
          if (reg_gnt_i) begin
            reg_req_o <= 1'b0;
            reg_we_o  <= 1'b0;
            if (reg_rvalid_i) begin
              state     <= RESP;
              d_valid_o <= 1'b1;
              d_data_o  <= resp_data;
              d_error_o <= reg_err_i;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (reg_rvalid_i) begin
            state     <= RESP;
            d_valid_o <= 1'b1;
            d_data_o  <= resp_data;
            d_error_o <= reg_err_i;
          end
        end
        RESP: begin
          if (d_ready_i) begin
            state     <= IDLE;
            d_valid_o <= 1'b0;
            d_error_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
